raid5_stripe_writer: RTL and testbench

RAID5_STRIPE_WRITER -- requirements
Module: raid5_stripe_writer

---
 rtl/raid5_stripe_writer.sv | 114 +++++++++++
 tb/tb_raid5_stripe_writer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/raid5_stripe_writer.sv
// RAID5 stripe writer: collects two host words A and B, computes P = A ^ B, and
// presents the rotated-parity stripe to three disks through a valid/ready handshake.
module raid5_stripe_writer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic [31:0]          data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic [31:0]          disk0_data,
  output logic [31:0]          disk1_data,
  output logic [31:0]          disk2_data,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [1:0]           parity_disk,
  output logic [CNT_WIDTH-1:0] stripe_count
);

  typedef enum logic [1:0] {IDLE, HAVE_A, WRITE} state_t;

  state_t               state_q, state_d;
  logic [31:0]          a_q, a_d;
  logic [31:0]          disk0_q, disk0_d, disk1_q, disk1_d, disk2_q, disk2_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [1:0]           parity_q, parity_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 accept;
  logic [31:0]          p;

  assign data_ready   = (state_q != WRITE);
  assign accept       = data_valid && data_ready;
  assign p            = a_q ^ data_in;
  assign disk0_data   = disk0_q;
  assign disk1_data   = disk1_q;
  assign disk2_data   = disk2_q;
  assign wr_valid     = wr_valid_q;
  assign parity_disk  = parity_q;
  assign stripe_count = count_q;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    disk0_d    = disk0_q;
    disk1_d    = disk1_q;
    disk2_d    = disk2_q;
    wr_valid_d = wr_valid_q;
    parity_d   = parity_q;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = data_in;
          state_d = HAVE_A;
        end
      end
      HAVE_A: begin
        if (accept) begin
          case (parity_q)
            2'd0:    begin disk0_d = p;   disk1_d = a_q;     disk2_d = data_in; end
            2'd1:    begin disk0_d = a_q; disk1_d = p;       disk2_d = data_in; end
            default: begin disk0_d = a_q; disk1_d = data_in; disk2_d = p;       end
          endcase
          wr_valid_d = 1'b1;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        if (wr_ready) begin
          wr_valid_d = 1'b0;
          state_d    = IDLE;
          parity_d   = (parity_q == 2'd2) ? 2'd0 : parity_q + 2'd1;
          count_d    = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over any handshake in flight.
    if (clear) begin
      state_d    = IDLE;
      a_d        = '0;
      disk0_d    = '0;
      disk1_d    = '0;
      disk2_d    = '0;
      wr_valid_d = 1'b0;
      parity_d   = 2'd0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      disk0_q    <= '0;
      disk1_q    <= '0;
      disk2_q    <= '0;
      wr_valid_q <= 1'b0;
      parity_q   <= 2'd0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      disk0_q    <= disk0_d;
      disk1_q    <= disk1_d;
      disk2_q    <= disk2_d;
      wr_valid_q <= wr_valid_d;
      parity_q   <= parity_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_raid5_stripe_writer.sv
// Directed bench for raid5_stripe_writer; a CNT_WIDTH=2 copy shares the stimulus
// so the counter wrap can be observed.
module tb_raid5_stripe_writer;
  logic        clk = 0;
  logic        n_rst, clear, data_valid, wr_ready;
  logic [31:0] data_in;
  logic        data_ready, wr_valid, s_data_ready, s_wr_valid;
  logic [31:0] d0, d1, d2, s_d0, s_d1, s_d2;
  logic [1:0]  parity_disk, s_parity_disk;
  logic [15:0] stripe_count;
  logic [1:0]  s_stripe_count;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  raid5_stripe_writer dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .disk0_data(d0), .disk1_data(d1), .disk2_data(d2),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .parity_disk(parity_disk),
    .stripe_count(stripe_count));

  raid5_stripe_writer #(.CNT_WIDTH(2)) dut_s (
    .clk(clk), .n_rst(n_rst), .clear(clear), .data_in(data_in), .data_valid(data_valid),
    .data_ready(s_data_ready), .disk0_data(s_d0), .disk1_data(s_d1), .disk2_data(s_d2),
    .wr_valid(s_wr_valid), .wr_ready(wr_ready), .parity_disk(s_parity_disk),
    .stripe_count(s_stripe_count));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_stripe(input logic [31:0] a, input logic [31:0] b);
    data_valid = 1; data_in = a; tick();
    data_in = b; tick();
    data_valid = 0;
  endtask

  task automatic complete();
    wr_ready = 1; tick(); wr_ready = 0;
  endtask

  task automatic do_clear();
    clear = 1; tick(); clear = 0;
  endtask

  task automatic test_reset();
    n_rst = 1; clear = 0; data_valid = 0; wr_ready = 0; data_in = 0;
    #1 n_rst = 0;
    #2;
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", data_ready); end
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
    checks++; if (parity_disk !== 2'd0) begin errors++; $display("FAIL reset_parity: got %0d expected 0", parity_disk); end
    checks++; if (stripe_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", stripe_count); end
    checks++; if ({d0, d1, d2} !== 96'd0) begin errors++; $display("FAIL reset_disks: got %h %h %h expected 0", d0, d1, d2); end
    #10 n_rst = 1;
    tick();
  endtask

  task automatic test_basic();
    wr_ready = 1;
    data_valid = 1; data_in = 32'h0000_00FF; tick();
    data_in = 32'h0000_0F0F; wr_ready = 0; tick();
    data_valid = 0;
    checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", wr_valid); end
    checks++; if ({d0, d1, d2} !== {32'h0000_0FF0, 32'h0000_00FF, 32'h0000_0F0F}) begin
      errors++; $display("FAIL basic_disks: got %h %h %h expected 00000ff0 000000ff 00000f0f", d0, d1, d2); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL basic_ready: got %b expected 0", data_ready); end
    complete();
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL basic_done: got %b expected 0", wr_valid); end
    checks++; if (parity_disk !== 2'd1) begin errors++; $display("FAIL basic_parity: got %0d expected 1", parity_disk); end
    checks++; if (stripe_count !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", stripe_count); end
  endtask

  task automatic test_rotation();
    logic [95:0] exp [4];
    logic [1:0]  exp_p [4];
    exp[0] = {32'h3333_3333, 32'h1111_1111, 32'h2222_2222}; exp_p[0] = 0;
    exp[1] = {32'h1111_1111, 32'h3333_3333, 32'h2222_2222}; exp_p[1] = 1;
    exp[2] = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333}; exp_p[2] = 2;
    exp[3] = exp[0];                                        exp_p[3] = 0;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      load_stripe(32'h1111_1111, 32'h2222_2222);
      checks++; if (parity_disk !== exp_p[i]) begin errors++; $display("FAIL rot_parity[%0d]: got %0d expected %0d", i, parity_disk, exp_p[i]); end
      checks++; if ({d0, d1, d2} !== exp[i]) begin errors++; $display("FAIL rot_disks[%0d]: got %h %h %h expected %h", i, d0, d1, d2, exp[i]); end
      checks++; if ((d0 ^ d1 ^ d2) !== 32'd0 || wr_valid !== 1'b1) begin
        errors++; $display("FAIL rot_xor[%0d]: got xor %h valid %b expected 0 1", i, d0 ^ d1 ^ d2, wr_valid); end
      complete();
    end
  endtask

  task automatic test_backpressure();
    load_stripe(32'hDEAD_BEEF, 32'h1234_5678);
    data_valid = 1; data_in = 32'hFFFF_FFFF; wr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (wr_valid !== 1'b1 || data_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hs[%0d]: got valid %b ready %b expected 1 0", i, wr_valid, data_ready); end
      checks++; if ({d0, d1, d2, parity_disk} !== {32'hDEAD_BEEF, 32'hCC99_E897, 32'h1234_5678, 2'd1}) begin
        errors++; $display("FAIL bp_hold[%0d]: got %h %h %h p%0d expected deadbeef cc99e897 12345678 p1", i, d0, d1, d2, parity_disk); end
      checks++; if (stripe_count !== 16'd4) begin errors++; $display("FAIL bp_count[%0d]: got %0d expected 4", i, stripe_count); end
    end
    data_valid = 0;
    complete();
    checks++; if (wr_valid !== 1'b0 || stripe_count !== 16'd5 || parity_disk !== 2'd2) begin
      errors++; $display("FAIL bp_done: got valid %b count %0d p%0d expected 0 5 2", wr_valid, stripe_count, parity_disk); end
  endtask

  task automatic test_abort();
    data_valid = 1; data_in = 32'hAAAA_0000; tick();
    data_in = 32'h0000_5555; clear = 1; tick(); clear = 0;
    data_valid = 0;
    checks++; if (parity_disk !== 2'd0 || stripe_count !== 16'd0 || wr_valid !== 1'b0 || data_ready !== 1'b1) begin
      errors++; $display("FAIL abort_state: got p%0d count %0d valid %b ready %b expected 0 0 0 1", parity_disk, stripe_count, wr_valid, data_ready); end
    load_stripe(32'h0000_000F, 32'h0000_00F0);
    checks++; if (wr_valid !== 1'b1 || {d0, d1, d2} !== {32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0}) begin
      errors++; $display("FAIL abort_next: got valid %b %h %h %h expected 1 000000ff 0000000f 000000f0", wr_valid, d0, d1, d2); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3 n_rst = 0;
    #1;
    checks++; if (wr_valid !== 1'b0 || s_wr_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", wr_valid); end
    checks++; if ({d0, d1, d2} !== 96'd0 || data_ready !== 1'b1) begin
      errors++; $display("FAIL async_out: got %h %h %h ready %b expected 0 1", d0, d1, d2, data_ready); end
    #2 n_rst = 1;
    wr_ready = 1; tick(); tick(); wr_ready = 0;
    checks++; if (wr_valid !== 1'b0 || parity_disk !== 2'd0 || stripe_count !== 16'd0 || data_ready !== 1'b1) begin
      errors++; $display("FAIL async_after: got valid %b p%0d count %0d ready %b expected 0 0 0 1", wr_valid, parity_disk, stripe_count, data_ready); end
    load_stripe(32'h0000_0001, 32'h0000_0002);
    checks++; if (wr_valid !== 1'b1 || {d0, d1, d2} !== {32'd3, 32'd1, 32'd2}) begin
      errors++; $display("FAIL async_resume: got valid %b %h %h %h expected 1 3 1 2", wr_valid, d0, d1, d2); end
    complete();
  endtask

  task automatic test_wrap();
    logic [1:0] exp_s [4];
    exp_s[0] = 1; exp_s[1] = 2; exp_s[2] = 3; exp_s[3] = 0;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      load_stripe(32'h0F0F_0000 + i, 32'h00F0_F000);
      complete();
      checks++; if (s_stripe_count !== exp_s[i]) begin errors++; $display("FAIL wrap_small[%0d]: got %0d expected %0d", i, s_stripe_count, exp_s[i]); end
      checks++; if (stripe_count !== 16'(i + 1)) begin errors++; $display("FAIL wrap_wide[%0d]: got %0d expected %0d", i, stripe_count, i + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
